// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one ibus request at a time, handles redirects.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned PCs raise out_exc with a NOP instead of a bus request.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_exc
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [XLEN-1:0]   pend_pc_reg, pend_pc_next;
  logic              kill_reg, kill_next;
  logic              out_valid_reg, out_valid_next;
  logic [XLEN-1:0]   out_pc_reg, out_pc_next;
  logic [31:0]       out_instr_reg, out_instr_next;
  logic              out_exc_reg, out_exc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      pend_pc_reg   <= '0;
      kill_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= '0;
      out_instr_reg <= '0;
      out_exc_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pend_pc_reg   <= pend_pc_next;
      kill_reg      <= kill_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_instr_reg <= out_instr_next;
      out_exc_reg   <= out_exc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    pend_pc_next   = pend_pc_reg;
    kill_next      = kill_reg;
    out_valid_next = out_valid_reg;
    out_pc_next    = out_pc_reg;
    out_instr_next = out_instr_reg;
    out_exc_next   = out_exc_reg;

    case (state_reg)
      IDLE: begin
        if (redirect_valid) pc_next = redirect_pc;
        state_next = REQ;
      end
      REQ: begin
        // An issued request is never withdrawn; a redirect only marks its data for discard.
        if (redirect_valid) begin
          pend_pc_next = redirect_pc;
          kill_next    = 1'b1;
        end
        if (iresp_addr_ok) state_next = WAIT;
      end
      WAIT: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            pc_next    = redirect_pc;
            kill_next  = 1'b0;
            state_next = REQ;
          end else if (kill_reg) begin
            pc_next    = pend_pc_reg;
            kill_next  = 1'b0;
            state_next = REQ;
          end else begin
            out_valid_next = 1'b1;
            out_pc_next    = pc_reg;
            out_instr_next = iresp_data;
            out_exc_next   = 1'b0;
            state_next     = HOLD;
          end
        end else if (redirect_valid) begin
          pend_pc_next = redirect_pc;
          kill_next    = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next        = redirect_pc;
          out_valid_next = 1'b0;
          state_next     = REQ;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (out_exc_reg) begin
            state_next = HALT;
          end else begin
            pc_next    = pc_reg + XLEN'(4);
            state_next = REQ;
          end
`else
          pc_next    = pc_reg + XLEN'(4);
          state_next = REQ;
`endif
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef FETCH_MISALIGN_CHECK_EN
    // Intercept every entry into REQ: a misaligned PC becomes an exception record, never a bus request.
    if (state_next == REQ && pc_next[1:0] != 2'b00) begin
      state_next     = HOLD;
      out_valid_next = 1'b1;
      out_pc_next    = pc_next;
      out_instr_next = NOP;
      out_exc_next   = 1'b1;
    end
`endif
  end

  assign ireq_valid = (state_reg == REQ);
  assign ireq_addr  = pc_reg;
  assign out_valid  = out_valid_reg;
  assign out_pc     = out_pc_reg;
  assign out_instr  = out_instr_reg;
  assign out_exc    = out_exc_reg;

endmodule
